// File: rtl/seq_scan_pkg.sv
// seq_scan_pkg: state encoding, reset configuration defaults and pattern-length width helper shared by seq_scan_controller and seq_match_shift
package seq_scan_pkg;
  typedef enum logic {IDLE, SHIFT} state_t;
  localparam logic [3:0] DEF_PATTERN = 4'b1011;
  localparam int DEF_LEN = 4;
  function automatic int len_w(input int pat_w);
    return $clog2(pat_w) + 1;
  endfunction
endpackage

// File: rtl/seq_match_shift.sv
// seq_match_shift: history shift register, saturating fill counter and masked pattern compare; ports clk/reset_n, clr, shift_en, bit_in, pattern, len, overlap -> match (strobe on the updated history)
module seq_match_shift import seq_scan_pkg::*; #(
  parameter int PAT_W = 8,
  localparam int LW = len_w(PAT_W)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             clr,
  input  logic             shift_en,
  input  logic             bit_in,
  input  logic             overlap,
  input  logic [PAT_W-1:0] pattern,
  input  logic [LW-1:0]    len,
  output logic             match
);
  logic [PAT_W-1:0] hist, hist_nx, mask;
  logic [LW-1:0] fill, fill_nx;
  always_comb begin
    hist_nx = (hist << 1) | PAT_W'(bit_in);
    fill_nx = fill == LW'(PAT_W) ? fill : fill + LW'(1);
    mask = ~({PAT_W{1'b1}} << len);
    match = shift_en && fill_nx >= len && ((hist_nx ^ pattern) & mask) == '0;
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      hist <= '0;
      fill <= '0;
    end else if (clr) begin
      hist <= '0;
      fill <= '0;
    end else if (shift_en) begin
      hist <= hist_nx;
      fill <= (match && !overlap) ? '0 : fill_nx;
    end
endmodule

// File: rtl/seq_scan_controller.sv
// seq_scan_controller: serialises DATA_W-bit words MSB-first into a runtime-programmed pattern matcher; ports clk/reset_n, cfg_we/cfg_pattern/cfg_len/cfg_overlap (IDLE only), in_valid/in_data/in_ready, busy, match_pulse, match_count, plus irq_clr/irq when SEQ_SCAN_IRQ_EN is defined
module seq_scan_controller import seq_scan_pkg::*; #(
  parameter int DATA_W = 8,
  parameter int PAT_W = 8,
  parameter int CNT_W = 8,
  localparam int LW = len_w(PAT_W)
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              cfg_we,
  input  logic [PAT_W-1:0]  cfg_pattern,
  input  logic [LW-1:0]     cfg_len,
  input  logic              cfg_overlap,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
`ifdef SEQ_SCAN_IRQ_EN
  input  logic              irq_clr,
  output logic              irq,
`endif
  output logic              in_ready,
  output logic              busy,
  output logic              match_pulse,
  output logic [CNT_W-1:0]  match_count
);
  localparam int IW = $clog2(DATA_W);
  state_t state, state_nx;
  logic [DATA_W-1:0] data;
  logic [IW-1:0] idx;
  logic [PAT_W-1:0] pattern;
  logic [LW-1:0] len;
  logic overlap, cfg_take, accept, match;
  always_comb begin
    cfg_take = state == IDLE && cfg_we;
    in_ready = state == IDLE && !cfg_we;
    busy = state == SHIFT;
    accept = in_ready && in_valid;
    state_nx = state == IDLE ? (accept ? SHIFT : IDLE) : (idx == '0 ? IDLE : SHIFT);
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) state <= IDLE;
    else state <= state_nx;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      data <= '0;
      idx <= '0;
      pattern <= PAT_W'(DEF_PATTERN);
      len <= LW'(DEF_LEN);
      overlap <= 1'b1;
      match_pulse <= 1'b0;
      match_count <= '0;
    end else begin
      match_pulse <= match;
      if (accept) begin
        data <= in_data;
        idx <= IW'(DATA_W - 1);
      end else if (busy) idx <= idx - IW'(1);
      if (cfg_take) begin
        pattern <= cfg_pattern;
        len <= (cfg_len == '0 || cfg_len > LW'(PAT_W)) ? LW'(PAT_W) : cfg_len;
        overlap <= cfg_overlap;
        match_count <= '0;
      end else if (match && match_count != '1) match_count <= match_count + CNT_W'(1);
    end
  seq_match_shift #(.PAT_W(PAT_W)) u_match (
    .clk(clk),
    .reset_n(reset_n),
    .clr(cfg_take),
    .shift_en(busy),
    .bit_in(data[idx]),
    .overlap(overlap),
    .pattern(pattern),
    .len(len),
    .match(match)
  );
`ifdef SEQ_SCAN_IRQ_EN
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) irq <= 1'b0;
    else irq <= match || (irq && !irq_clr);
`endif
endmodule

// File: tb/tb_seq_scan_controller.sv
// tb_seq_scan_controller: scoreboard bench driving directed words with hand-derived match positions into seq_scan_controller
module tb_seq_scan_controller;
  logic clk = 1'b0, reset_n, cfg_we = 1'b0, cfg_overlap = 1'b0, in_valid = 1'b0;
  logic [7:0] cfg_pattern = '0, in_data = '0;
  logic [3:0] cfg_len = '0;
  logic in_ready, busy, match_pulse;
  logic [7:0] match_count;
  typedef struct {int cyc; int cnt;} exp_t;
  exp_t q[$];
  int cyc = 0, n_cmp = 0, n_bad = 0, exp_cnt = 0;

  seq_scan_controller dut (
    .clk(clk), .reset_n(reset_n), .cfg_we(cfg_we), .cfg_pattern(cfg_pattern),
    .cfg_len(cfg_len), .cfg_overlap(cfg_overlap), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .busy(busy), .match_pulse(match_pulse), .match_count(match_count)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int req);
    n_cmp++;
    if (act != req) begin
      n_bad++;
      $display("FAIL %s: got %0d, required %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  always @(negedge clk)
    if (reset_n === 1'b1 && match_pulse) begin
      exp_t e;
      if (q.size() == 0) check("unexpected match_pulse cycle", cyc, -1);
      else begin
        e = q.pop_front();
        check("match_pulse cycle", cyc, e.cyc);
        check("match_count at pulse", match_count, e.cnt);
      end
    end

  task automatic do_cfg(input logic [7:0] p, input logic [3:0] l, input logic ov);
    @(negedge clk);
    cfg_we = 1'b1; cfg_pattern = p; cfg_len = l; cfg_overlap = ov;
    @(negedge clk);
    cfg_we = 1'b0;
    exp_cnt = 0;
  endtask

  task automatic accept(input logic [7:0] w, output int a);
    @(negedge clk);
    check("in_ready before accept", in_ready, 1);
    in_valid = 1'b1; in_data = w;
    @(posedge clk);
    #1 a = cyc;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  // mpos bit i set: a match completes on the i-th serialised bit (i=0 is the MSB)
  task automatic send(input logic [7:0] w, input logic [7:0] mpos);
    int a;
    int k;
    accept(w, a);
    for (int i = 0; i < 8; i++)
      if (mpos[i]) begin
        exp_cnt = exp_cnt < 255 ? exp_cnt + 1 : 255;
        q.push_back('{a + 1 + i, exp_cnt});
      end
    k = 0;
    while (!in_ready && k < 20) begin
      @(negedge clk);
      k++;
    end
    check("word occupancy cycles", cyc - a + 1, 9);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, cycle %0d", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int a;
    reset_n = 1'b1;
    #1 reset_n = 1'b0;
    #1;
    check("reset in_ready", in_ready, 1);
    check("reset busy", busy, 0);
    check("reset match_pulse", match_pulse, 0);
    check("reset match_count", match_count, 0);
    @(negedge clk);
    reset_n = 1'b1;

    send(8'b10110110, 8'b0100_1000);
    check("overlap count", match_count, 2);

    do_cfg(8'h0B, 4'd4, 1'b0);
    send(8'b10110110, 8'b0000_1000);
    check("non-overlap count", match_count, 1);

    do_cfg(8'h0B, 4'd4, 1'b1);
    send(8'b00000101, 8'b0000_0000);
    send(8'b10000000, 8'b0000_0001);
    check("cross-word count", match_count, 1);

    do_cfg(8'h01, 4'd1, 1'b1);
    repeat (32) send(8'hFF, 8'hFF);
    check("saturated count", match_count, 255);

    do_cfg(8'hB6, 4'd0, 1'b1);
    send(8'b10110110, 8'b1000_0000);
    check("len 0 clamp count", match_count, 1);
    do_cfg(8'hB6, 4'd9, 1'b1);
    send(8'b10110110, 8'b1000_0000);
    check("len 9 clamp count", match_count, 1);

    @(negedge clk);
    cfg_we = 1'b1; cfg_pattern = 8'h06; cfg_len = 4'd4; cfg_overlap = 1'b1;
    in_valid = 1'b1; in_data = 8'hFF;
    #1 check("in_ready with cfg_we", in_ready, 0);
    @(negedge clk);
    cfg_we = 1'b0; in_valid = 1'b0; exp_cnt = 0;
    check("busy after cfg/valid collision", busy, 0);
    check("count cleared by cfg", match_count, 0);
    fork
      send(8'b10110110, 8'b1001_0000);
      begin
        repeat (4) @(negedge clk);
        cfg_we = 1'b1; cfg_pattern = 8'h01; cfg_len = 4'd1; cfg_overlap = 1'b0;
        @(negedge clk);
        cfg_we = 1'b0;
      end
    join
    check("count after cfg_we in SHIFT", match_count, 2);
    send(8'b10110110, 8'b1001_0000);
    check("count with config kept", match_count, 4);

    accept(8'h00, a);
    repeat (3) @(negedge clk);
    reset_n = 1'b0;
    #1;
    check("async reset busy", busy, 0);
    check("async reset in_ready", in_ready, 1);
    check("async reset match_count", match_count, 0);
    check("async reset match_pulse", match_pulse, 0);
    exp_cnt = 0;
    @(negedge clk);
    reset_n = 1'b1;
    send(8'b10110110, 8'b0100_1000);
    check("default config restored count", match_count, 2);

    repeat (3) @(negedge clk);
    check("scoreboard drained", q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
